// File: rtl/letc_core_pkg.sv
// Shared types and constants for the LETC Core pipeline.
// Holds the PC type, stage bundles, stage indices and per-stage FSM encodings.
package letc_core_pkg;

    typedef logic [31:0] pc_t;

    localparam pc_t RESET_PC = 32'h0000_0000;
    localparam pc_t PC_STEP  = 32'h0000_0004;

    typedef enum logic [2:0] {
        STAGE_F1 = 3'd0,
        STAGE_F2 = 3'd1,
        STAGE_D  = 3'd2,
        STAGE_E1 = 3'd3,
        STAGE_E2 = 3'd4,
        STAGE_M  = 3'd5,
        STAGE_W  = 3'd6
    } stage_idx_e;

    typedef struct packed {
        pc_t pc;
    } f1_to_f2_s;

    typedef enum logic [1:0] {
        F1_BOOT   = 2'd0,
        F1_RUN    = 2'd1,
        F1_HALTED = 2'd2
    } f1_state_e;

    // Selects the next fetch PC; a trap outranks a branch and both outrank sequential advance.
    function automatic pc_t next_pc(input logic trap, input pc_t trap_target,
                                    input logic branch, input pc_t branch_target,
                                    input logic advance, input pc_t pc);
        if (trap)
            return trap_target;
        else if (branch)
            return branch_target;
        else if (advance)
            return pc + PC_STEP;
        else
            return pc;
    endfunction

endpackage

// File: rtl/letc_core_stage_f1.sv
// Fetch-1 stage: owns the fetch PC, issues L1I requests and applies execute/writeback redirects.
// Produces the registered PC bundle consumed by Fetch-2.
module letc_core_stage_f1
    import letc_core_pkg::*;
#(
    parameter pc_t RESET_PC_P = RESET_PC
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_stall,
    input  logic      i_halt,
    input  logic      i_branch_redirect,
    input  pc_t       i_branch_target,
    input  logic      i_trap_redirect,
    input  pc_t       i_trap_target,
    output logic      o_l1i_req_valid,
    output pc_t       o_l1i_req_addr,
    input  logic      i_l1i_req_ready,
    output logic      o_f1_to_f2_valid,
    output f1_to_f2_s o_f1_to_f2
);

    f1_state_e state_reg, state_next;
    pc_t       pc_reg, pc_next;
    logic      out_valid_reg;
    f1_to_f2_s out_reg;

    logic redirect;
    logic advance;

    assign redirect = i_trap_redirect | i_branch_redirect;
    assign advance  = o_l1i_req_valid & i_l1i_req_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_reg <= F1_BOOT;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            F1_BOOT:   state_next = F1_RUN;
            F1_RUN:    if (i_halt && !redirect) state_next = F1_HALTED;
            F1_HALTED: if (redirect) state_next = F1_RUN;
            default:   state_next = F1_BOOT;
        endcase
    end

    // Any redirect, stall or halt suppresses the request so the L1I never sees a stale address.
    always_comb begin
        o_l1i_req_valid = 1'b0;
        if (state_reg == F1_RUN)
            o_l1i_req_valid = ~i_stall & ~redirect & ~i_halt;
    end

    assign o_l1i_req_addr = pc_reg;

    assign pc_next = next_pc(i_trap_redirect, i_trap_target,
                             i_branch_redirect, i_branch_target,
                             advance, pc_reg);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            pc_reg <= RESET_PC_P;
        else
            pc_reg <= pc_next;
    end

    // Flush beats stall; a stalled F2 keeps its current bundle untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
        end else if (redirect) begin
            out_valid_reg <= 1'b0;
        end else if (i_stall) begin
            out_valid_reg <= out_valid_reg;
        end else if (advance) begin
            out_valid_reg <= 1'b1;
            out_reg.pc    <= pc_reg;
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign o_f1_to_f2_valid = out_valid_reg;
    assign o_f1_to_f2       = out_reg;

endmodule

// File: tb/tb_letc_core_stage_f1.sv
// Self-checking bench for the Fetch-1 stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
`timescale 1ns/1ps
module tb_letc_core_stage_f1;
    import letc_core_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      stall, halt, br, tr, ready;
    pc_t       bt, tt;
    logic      req_valid;
    pc_t       req_addr;
    logic      f2_valid;
    f1_to_f2_s f2;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    pc_t  m_pc;
    logic m_boot, m_halted, m_v;
    pc_t  m_out;

    letc_core_stage_f1 #(.RESET_PC_P(32'h0000_0000)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_stall           (stall),
        .i_halt            (halt),
        .i_branch_redirect (br),
        .i_branch_target   (bt),
        .i_trap_redirect   (tr),
        .i_trap_target     (tt),
        .o_l1i_req_valid   (req_valid),
        .o_l1i_req_addr    (req_addr),
        .i_l1i_req_ready   (ready),
        .o_f1_to_f2_valid  (f2_valid),
        .o_f1_to_f2        (f2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_req();
        return !m_boot && !m_halted && !stall && !halt && !(br || tr);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_boot = 1'b1; m_halted = 1'b0; m_v = 1'b0; m_out = 32'h0;
    endtask

    task automatic drive(input logic s, input logic h, input logic b, input pc_t btgt,
                         input logic t, input pc_t ttgt, input logic r);
        stall = s; halt = h; br = b; bt = btgt; tr = t; tt = ttgt; ready = r;
        #1;
    endtask

    // Advance one clock and update the model from the inputs held across the edge.
    task automatic tick();
        logic redir, adv;
        redir = br || tr;
        adv   = exp_req() && ready;
        @(posedge clk);
        if (adv) $display("fetch accepted pc=0x%08h", m_pc);
        if (redir) m_v = 1'b0;
        else if (stall) m_v = m_v;
        else if (adv) begin m_v = 1'b1; m_out = m_pc; end
        else m_v = 1'b0;
        if (tr) m_pc = tt;
        else if (br) m_pc = bt;
        else if (adv) m_pc = m_pc + 32'd4;
        if (m_boot) m_boot = 1'b0;
        else if (m_halted) begin if (redir) m_halted = 1'b0; end
        else if (halt && !redir) m_halted = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (req_valid !== 1'b0 || f2_valid !== 1'b0 || f2 !== '0 || req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset: req_valid=%b f2_valid=%b f2=0x%08h addr=0x%08h, want 0 0 0 0",
                     req_valid, f2_valid, f2, req_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_sequential();
        pc_t want;
        // BOOT cycle: no request
        n_checks++;
        if (req_valid !== 1'b0) begin
            n_errors++; $display("FAIL boot_noreq: req_valid=%b want 0", req_valid);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            want = 32'(i * 4);
            n_checks++;
            if (req_valid !== 1'b1 || req_addr !== want) begin
                n_errors++;
                $display("FAIL seq_req%0d: valid=%b addr=0x%08h want 1 0x%08h", i, req_valid, req_addr, want);
            end
            tick();
            n_checks++;
            if (f2_valid !== 1'b1 || f2.pc !== want) begin
                n_errors++;
                $display("FAIL seq_f2_%0d: valid=%b pc=0x%08h want 1 0x%08h", i, f2_valid, f2.pc, want);
            end
        end
    endtask

    task automatic test_ready_wait();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (req_valid !== 1'b1 || req_addr !== 32'h8) begin
                n_errors++;
                $display("FAIL wait_req%0d: valid=%b addr=0x%08h want 1 0x00000008", i, req_valid, req_addr);
            end
            tick();
            n_checks++;
            if (f2_valid !== 1'b0) begin
                n_errors++; $display("FAIL wait_f2_%0d: valid=%b want 0", i, f2_valid);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            tick();
            n_checks++;
            if (f2_valid !== 1'b1 || f2.pc !== 32'(8 + 4 * i)) begin
                n_errors++;
                $display("FAIL wait_resume%0d: valid=%b pc=0x%08h want 1 0x%08h", i, f2_valid, f2.pc, 8 + 4 * i);
            end
        end
    endtask

    task automatic test_branch_stall();
        drive(1, 0, 1, 32'h100, 0, 0, 1);
        n_checks++;
        if (req_valid !== 1'b0) begin
            n_errors++; $display("FAIL br_stall_noreq: valid=%b want 0", req_valid);
        end
        tick();
        n_checks++;
        if (f2_valid !== 1'b0) begin
            n_errors++; $display("FAIL br_stall_flush: f2_valid=%b want 0", f2_valid);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL br_target: valid=%b addr=0x%08h want 1 0x00000100", req_valid, req_addr);
        end
        tick();
    endtask

    task automatic test_trap_priority();
        drive(0, 0, 1, 32'h100, 1, 32'h200, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL trap_prio: valid=%b addr=0x%08h want 1 0x00000200", req_valid, req_addr);
        end
        tick();
    endtask

    task automatic test_halt();
        drive(0, 0, 1, 32'h40, 0, 0, 1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 1);
        n_checks++;
        if (req_valid !== 1'b0 || req_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL halt_entry: valid=%b addr=0x%08h want 0 0x00000040", req_valid, req_addr);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(logic'(i[0]), 0, 0, 0, 0, 0, 1);
            n_checks++;
            if (req_valid !== 1'b0 || req_addr !== 32'h40) begin
                n_errors++;
                $display("FAIL halted_idle%0d: valid=%b addr=0x%08h want 0 0x00000040", i, req_valid, req_addr);
            end
            tick();
        end
        drive(0, 0, 0, 0, 1, 32'h80, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h80) begin
            n_errors++;
            $display("FAIL halt_exit: valid=%b addr=0x%08h want 1 0x00000080", req_valid, req_addr);
        end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0 || f2.pc !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap: valid=%b addr=0x%08h f2pc=0x%08h want 1 0x00000000 0xfffffffc",
                     req_valid, req_addr, f2.pc);
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (req_valid !== 1'b0 || f2_valid !== 1'b0 || f2 !== '0 || req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: req=%b f2v=%b f2=0x%08h addr=0x%08h want 0 0 0 0",
                     req_valid, f2_valid, f2, req_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL restart: valid=%b addr=0x%08h want 1 0x00000000", req_valid, req_addr);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) == 0), pc_t'($urandom),
                  ($urandom_range(0, 19) == 0), pc_t'($urandom),
                  ($urandom_range(0, 3) != 0));
            n_checks++;
            if (req_valid !== exp_req() || req_addr !== m_pc) begin
                n_errors++;
                $display("FAIL rand_req%0d: valid=%b addr=0x%08h want %b 0x%08h",
                         i, req_valid, req_addr, exp_req(), m_pc);
            end
            tick();
            n_checks++;
            if (f2_valid !== m_v || (m_v && f2.pc !== m_out)) begin
                n_errors++;
                $display("FAIL rand_f2_%0d: valid=%b pc=0x%08h want %b 0x%08h",
                         i, f2_valid, f2.pc, m_v, m_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_wait();
        test_branch_stall();
        test_trap_priority();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
